midi_encoder: RTL

- Transmit-side counterpart of the MIDI note decoder.
- Accepts note-on/note-off events from the sounder/sequencer logic and buffers them in a small FIFO.
- Serializes each event into 3-byte MIDI channel messages: status, note, velocity.
- Drives the byte-strobe interface of the UART transmitter feeding the MIDI OUT jack.

---
 rtl/midi_encoder_if.sv | 39 +++
 rtl/midi_encoder.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/midi_encoder_if.sv
`default_nettype none
//============================================================================
// Module      : midi_encoder_if
// Description : Event-request and UART byte-strobe bundle for midi_encoder.
//               slave  - the encoder side (takes events and tx_busy, drives
//                        ready, the byte strobe and the status outputs).
//               master - the sequencer / transmitter side.
// Signals     : i_ev_valid, o_ev_ready, i_ev_on, i_ev_ch[3:0],
//               i_ev_note[6:0], i_ev_vel[6:0]   event handshake
//               o_tx_flg, o_tx_data[7:0], i_tx_busy  UART byte strobe
//               o_fifo_cnt[FIFO_AW:0], o_busy         status
// Revision    : 1.0 - initial release
//============================================================================
interface midi_encoder_if #(
    parameter int FIFO_AW = 3
);
    logic               i_ev_valid;
    logic               o_ev_ready;
    logic               i_ev_on;
    logic [3:0]         i_ev_ch;
    logic [6:0]         i_ev_note;
    logic [6:0]         i_ev_vel;
    logic               o_tx_flg;
    logic [7:0]         o_tx_data;
    logic               i_tx_busy;
    logic [FIFO_AW:0]   o_fifo_cnt;
    logic               o_busy;

    modport slave (
        input  i_ev_valid, i_ev_on, i_ev_ch, i_ev_note, i_ev_vel, i_tx_busy,
        output o_ev_ready, o_tx_flg, o_tx_data, o_fifo_cnt, o_busy
    );

    modport master (
        output i_ev_valid, i_ev_on, i_ev_ch, i_ev_note, i_ev_vel, i_tx_busy,
        input  o_ev_ready, o_tx_flg, o_tx_data, o_fifo_cnt, o_busy
    );
endinterface
`default_nettype wire

// File: rtl/midi_encoder.sv
`default_nettype none
//============================================================================
// Module      : midi_encoder
// Description : Buffers note-on/note-off events in a 2^FIFO_AW deep FIFO and
//               serialises each into a MIDI channel message (status, note,
//               velocity) on the byte-strobe interface of a UART transmitter.
// Ports       : i_clk          system clock
//               i_res          asynchronous reset, active high
//               bus (slave)    event handshake, byte strobe, status
// Parameters  : FIFO_AW        FIFO address width (depth = 2^FIFO_AW)
// Options     : MIDI_RUNNING_STATUS_EN - when defined, note-off is sent as
//               9n/vel 0 and a status byte equal to the previously sent one
//               is omitted (running status, 2-byte messages).
// Revision    : 1.0 - initial release
//============================================================================
module midi_encoder #(
    parameter int FIFO_AW = 3
) (
    input  wire logic     i_clk,
    input  wire logic     i_res,
    midi_encoder_if.slave bus
);

    localparam int               c_depth   = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] c_ptr_one = {{FIFO_AW{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_POP  = 2'd1,
        ST_SEND = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Event FIFO. Entry layout: {on, ch[3:0], note[6:0], vel[6:0]}.
    // Pointers carry one extra wrap bit so full and empty are distinct.
    // ------------------------------------------------------------------
    logic [18:0]      r_mem [c_depth];
    logic [FIFO_AW:0] r_wr_ptr;
    logic [FIFO_AW:0] r_rd_ptr;

    logic             w_empty;
    logic             w_full;
    logic             w_push;
    logic [18:0]      w_entry;
    logic [18:0]      w_head;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[FIFO_AW] != r_rd_ptr[FIFO_AW]) &&
                     (r_wr_ptr[FIFO_AW-1:0] == r_rd_ptr[FIFO_AW-1:0]);
    assign w_push  = bus.i_ev_valid & ~w_full;
    assign w_entry = {bus.i_ev_on, bus.i_ev_ch, bus.i_ev_note, bus.i_ev_vel};
    assign w_head  = r_mem[r_rd_ptr[FIFO_AW-1:0]];

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[FIFO_AW-1:0]] <= w_entry;
        end
    end

    always_ff @(posedge i_clk or posedge i_res) begin
        if (i_res) begin
            r_wr_ptr <= '0;
        end else if (w_push) begin
            r_wr_ptr <= r_wr_ptr + c_ptr_one;
        end
    end

    // ------------------------------------------------------------------
    // Message encoding of the FIFO head.
    // ------------------------------------------------------------------
    logic [7:0] w_head_status;
    logic [6:0] w_head_vel;

`ifdef MIDI_RUNNING_STATUS_EN
    // Note-off travels as note-on with zero velocity so that on/off runs
    // on one channel share a status byte.
    assign w_head_status = {4'h9, w_head[17:14]};
    assign w_head_vel    = w_head[18] ? w_head[6:0] : 7'h00;
`else
    assign w_head_status = {(w_head[18] ? 4'h9 : 4'h8), w_head[17:14]};
    assign w_head_vel    = w_head[6:0];
`endif

    // ------------------------------------------------------------------
    // Serialiser FSM.
    // ------------------------------------------------------------------
    state_t     r_state;
    logic [1:0] r_idx;
    logic [7:0] r_status;
    logic [6:0] r_note;
    logic [6:0] r_vel;
    logic       r_tx_flg;
    logic [7:0] r_tx_data;
    logic [7:0] w_cur_byte;
`ifdef MIDI_RUNNING_STATUS_EN
    logic [7:0] r_last_status;
`endif

    always_comb begin
        w_cur_byte = r_status;
        case (r_idx)
            2'd1:    w_cur_byte = {1'b0, r_note};
            2'd2:    w_cur_byte = {1'b0, r_vel};
            default: w_cur_byte = r_status;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_res) begin
        if (i_res) begin
            r_state       <= ST_IDLE;
            r_idx         <= 2'd0;
            r_status      <= 8'h00;
            r_note        <= 7'h00;
            r_vel         <= 7'h00;
            r_rd_ptr      <= '0;
            r_tx_flg      <= 1'b0;
            r_tx_data     <= 8'h00;
`ifdef MIDI_RUNNING_STATUS_EN
            r_last_status <= 8'h00;
`endif
        end else begin
            // The strobe is a single-cycle pulse; only SEND raises it.
            r_tx_flg <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        r_state <= ST_POP;
                    end
                end
                ST_POP: begin
                    r_status <= w_head_status;
                    r_note   <= w_head[13:7];
                    r_vel    <= w_head_vel;
                    r_rd_ptr <= r_rd_ptr + c_ptr_one;
`ifdef MIDI_RUNNING_STATUS_EN
                    r_idx    <= (w_head_status == r_last_status) ? 2'd1 : 2'd0;
`else
                    r_idx    <= 2'd0;
`endif
                    r_state  <= ST_SEND;
                end
                ST_SEND: begin
                    if (!bus.i_tx_busy) begin
                        r_tx_flg  <= 1'b1;
                        r_tx_data <= w_cur_byte;
`ifdef MIDI_RUNNING_STATUS_EN
                        if (r_idx == 2'd0) begin
                            r_last_status <= r_status;
                        end
`endif
                        r_state   <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    // The transmitter raises busy one cycle after the strobe,
                    // so busy is not trusted in this cycle.
                    if (r_idx == 2'd2) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_idx   <= r_idx + 2'd1;
                        r_state <= ST_SEND;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs.
    // ------------------------------------------------------------------
    assign bus.o_ev_ready = ~w_full;
    assign bus.o_tx_flg   = r_tx_flg;
    assign bus.o_tx_data  = r_tx_data;
    assign bus.o_fifo_cnt = r_wr_ptr - r_rd_ptr;
    assign bus.o_busy     = (r_state != ST_IDLE) | ~w_empty;

endmodule
`default_nettype wire
